// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes size/sign, drives a word-aligned memory port, extracts load data.
// Latency: 2 edges accept->response with immediate ack, 1 edge for illegal/misaligned; timeout aborts.
// Backpressure: req_ready only in IDLE; one access outstanding; mem side waits on mem_ack.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept, req_ok, timeout_hit, in_bus;
    logic [31:0] byte_word, load_ext;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign accept      = req_valid && req_ready;
    assign timeout_hit = (cnt_q == TO_LAST);
    assign in_bus      = (state == BUS);

    // Legality covers both funct3 encoding and natural alignment of the access size.
    always_comb begin
        req_ok = 1'b0;
        case (req_funct3)
            3'b000:  req_ok = 1'b1;
            3'b001:  req_ok = ~req_addr[0];
            3'b010:  req_ok = (req_addr[1:0] == 2'b00);
            3'b100:  req_ok = ~req_we;
            3'b101:  req_ok = ~req_we & ~req_addr[0];
            default: req_ok = 1'b0;
        endcase
    end

    assign byte_word = mem_rdata >> {addr_q[1:0], 3'b000};
    assign byte_sel  = byte_word[7:0];
    assign half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
        if (we_q) load_ext = 32'd0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_ok ? BUS : RESP;
            BUS:     if (mem_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= in_bus ? cnt_q + 8'd1 : 8'd0;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (!req_ok) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b1;
                end
            end
            // mem_ack wins over a timeout landing on the same edge.
            if (in_bus && mem_ack) begin
                rdata_q <= load_ext;
                err_q   <= 1'b0;
            end else if (in_bus && timeout_hit) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = 32'd0;
        if (in_bus && we_q) begin
            case (f3_q)
                3'b000: begin
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                3'b001: begin
                    mem_wstrb = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE) && rst_n;
    assign mem_req    = in_bus;
    assign mem_we     = in_bus && we_q;
    assign mem_addr   = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized accesses
// scored against a behavioural model of the RV32I load/store rules.
module tb_load_store_unit;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_chk  = 0;
    int n_pass = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(bit we, logic [2:0] f3, logic [31:0] a);
        int nbytes;
        bit enc_ok;
        enc_ok = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        nbytes = 1 << (f3 % 4);
        return enc_ok && ((a % nbytes) == 0);
    endfunction

    function automatic logic [3:0] m_strb(bit we, logic [2:0] f3, logic [31:0] a);
        int nbytes;
        if (!we) return 4'd0;
        nbytes = 1 << (f3 % 4);
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(bit we, logic [2:0] f3, logic [31:0] d);
        if (!we) return 32'd0;
        if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        longint v;
        if (we) return 32'd0;
        case (f3)
            3'd0: begin v = (longint'(rd) >> (8 * (a % 4))) & 255;    if (v >= 128) v -= 256; end
            3'd1: begin v = (longint'(rd) >> (16 * ((a / 2) % 2))) & 65535; if (v >= 32768) v -= 65536; end
            3'd4: v = (longint'(rd) >> (8 * (a % 4))) & 255;
            3'd5: v = (longint'(rd) >> (16 * ((a / 2) % 2))) & 65535;
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    // One complete access: ack arrives in BUS cycle 'dly' (0-based), or never if dly >= TO.
    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int dly);
        int  waited = 0;
        bit  ok;
        while (!req_ready && waited < 20) begin tick(); waited++; end
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick();
        ok = m_legal(we, f3, a);
        if (!ok) begin
            chk("err_path_resp", {resp_valid, resp_err, resp_rdata, mem_req},
                {1'b1, 1'b1, 32'd0, 1'b0});
        end else begin
            for (int k = 0; k < TO + 4; k++) begin
                // Scramble the request bus: the unit must use its registered copy.
                req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                chk("bus_ctrl", {mem_req, mem_we, mem_wstrb, resp_valid, req_ready},
                    {1'b1, we, m_strb(we, f3, a), 1'b0, 1'b0});
                chk("bus_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("bus_wdata", mem_wdata, m_wdata(we, f3, wd));
                mem_ack   = (k == dly);
                mem_rdata = (k == dly) ? rd : $urandom;
                tick();
                mem_ack = 1'b0;
                if (k == dly) begin
                    chk("ok_resp", {resp_valid, resp_err, resp_rdata, mem_req},
                        {1'b1, 1'b0, m_load(we, f3, a, rd), 1'b0});
                    break;
                end
                if (k + 1 == TO) begin
                    chk("timeout_resp", {resp_valid, resp_err, resp_rdata, mem_req},
                        {1'b1, 1'b1, 32'd0, 1'b0});
                    break;
                end
                if (k == TO + 3) chk("bus_exit_bound", 1'b0, 1'b1);
            end
        end
        req_valid = 1'($urandom);
        tick();
        req_valid = 1'b0;
        chk("idle_after_resp", {resp_valid, resp_err, resp_rdata, mem_req, req_ready},
            {1'b0, 1'b0, 32'd0, 1'b0, 1'b1});
        // Stray ack while idle must not disturb anything.
        mem_ack = 1'($urandom);
        tick();
        mem_ack = 1'b0;
        chk("idle_stray_ack", {resp_valid, mem_req, req_ready}, {1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        chk("reset_outputs", {req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we,
                              mem_addr, mem_wstrb},
            {1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0});
        chk("reset_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", req_ready, 1'b1);

        do_access(1'b0, 3'd0, 32'h103, 32'h0,         32'h80FF_FF7F, 0); // LB sign-extend
        do_access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h0,         0); // SH upper half
        do_access(1'b0, 3'd2, 32'h101, 32'h0,         32'h0,         0); // LW misaligned
        do_access(1'b0, 3'd5, 32'h12,  32'h0,         32'hBEEF_0000, 5); // LHU, ack on timeout edge
        do_access(1'b0, 3'd2, 32'h40,  32'h0,         32'h0,        99); // timeout
        do_access(1'b1, 3'd4, 32'h40,  32'h0,         32'h0,         0); // illegal store funct3
        do_access(1'b0, 3'd3, 32'h40,  32'h0,         32'h0,         0); // illegal load funct3

        // Reset in the middle of a bus access aborts it without a response.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80;
        tick();
        req_valid = 1'b0;
        chk("pre_reset_bus", mem_req, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("reset_in_bus", {mem_req, resp_valid, req_ready}, {1'b0, 1'b0, 1'b0});
        tick();
        chk("reset_hold", {mem_req, resp_valid, req_ready}, {1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        #1;
        chk("ready_after_abort", {req_ready, resp_valid}, {1'b1, 1'b0});
        do_access(1'b0, 3'd2, 32'h0, 32'h0, 32'hCAFE_F00D, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            do_access(1'($urandom), 3'($urandom), a, $urandom, $urandom,
                      int'($urandom_range(0, TO + 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
